// File: rtl/ulpi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ulpi_pkg: shared ULPI constants, RxCmd field positions, link FSM.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ulpi_pkg;

  localparam logic [1:0] TXCMD_REGW = 2'b10;
  localparam logic [1:0] TXCMD_REGR = 2'b11;
  localparam logic [1:0] TXCMD_TX   = 2'b01;

  localparam logic [5:0] REG_FUNC_CTRL = 6'h04;

  localparam int RXCMD_LINESTATE_LSB = 0;
  localparam int RXCMD_LINESTATE_MSB = 1;
  localparam int RXCMD_VBUS_LSB      = 2;
  localparam int RXCMD_VBUS_MSB      = 3;
  localparam int RXCMD_RXEVENT_LSB   = 4;
  localparam int RXCMD_RXEVENT_MSB   = 5;
  localparam int RXCMD_ID_BIT        = 6;

  typedef enum logic [2:0] {
    ST_WAIT_PHY   = 3'd0,
    ST_POST_RESET = 3'd1,
    ST_WR_CMD     = 3'd2,
    ST_WR_DATA    = 3'd3,
    ST_WR_STP     = 3'd4,
    ST_DONE       = 3'd5
  } link_state_e;

  function automatic logic [7:0] txcmd_regw(input logic [5:0] addr);
    return {TXCMD_REGW, addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ulpi_link.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ulpi_link: bus turnaround, RxCmd capture and one register write.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ulpi_link
  import ulpi_pkg::*;
#(
  parameter logic [5:0] FUNC_CTRL_ADDR = REG_FUNC_CTRL,
  parameter logic [7:0] FUNC_CTRL_VAL  = 8'h45
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       dir_i,
  input  logic       nxt_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe_o,
  output logic       stp_o,
  output logic       done_o,
  output logic [7:0] rxcmd_o
);

  link_state_e state_q, state_d;
  logic        dir_q;
  logic        rx_seen_q;
  logic        done_q;
  logic [7:0]  rxcmd_q;
  logic        rx_capture;

  assign rx_capture = dir_i & dir_q & ~nxt_i;
  // Released combinationally so the bus is freed in the very cycle DIR rises.
  assign data_oe_o  = ~dir_i & ~dir_q;
  assign done_o     = done_q | (state_q == ST_WR_STP);
  assign rxcmd_o    = rxcmd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_WAIT_PHY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q     <= 1'b1;
      rx_seen_q <= 1'b0;
      done_q    <= 1'b0;
      rxcmd_q   <= 8'h00;
    end else begin
      dir_q <= dir_i;
      if (rx_capture) begin
        rxcmd_q   <= data_i;
        rx_seen_q <= 1'b1;
      end
      if (state_q == ST_WR_STP) begin
        done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_PHY:   if (!dir_i && dir_q) state_d = ST_POST_RESET;
      ST_POST_RESET: if (rx_seen_q && !dir_i && !dir_q) state_d = ST_WR_CMD;
      ST_WR_CMD: begin
        if (dir_i)      state_d = ST_POST_RESET;
        else if (nxt_i) state_d = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        if (dir_i)      state_d = ST_POST_RESET;
        else if (nxt_i) state_d = ST_WR_STP;
      end
      ST_WR_STP:     state_d = ST_DONE;
      ST_DONE:       state_d = ST_DONE;
      default:       state_d = ST_WAIT_PHY;
    endcase
  end

  always_comb begin
    data_o = 8'h00;
    stp_o  = 1'b0;
    case (state_q)
      ST_WR_CMD:  data_o = txcmd_regw(FUNC_CTRL_ADDR);
      ST_WR_DATA: data_o = FUNC_CTRL_VAL;
      ST_WR_STP:  stp_o  = 1'b1;
      default:    data_o = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/usb_ulpi_top.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | usb_ulpi_top: ULPI PHY bring-up, Function Control write, done LED. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module usb_ulpi_top
  import ulpi_pkg::*;
#(
  parameter logic [5:0] FUNC_CTRL_ADDR = REG_FUNC_CTRL,
  parameter logic [7:0] FUNC_CTRL_VAL  = 8'h45
) (
  input  logic       USB_CLKIN,
  input  logic       NRST,
  input  logic       CLK,
  inout  wire  [7:0] USB_DATA,
  input  logic       USB_DIR,
  input  logic       USB_NXT,
  input  logic       USB_FAULTN,
  output logic       USB_STP,
  output logic       USB_RESETN,
  output logic       USB_CS,
  output logic       LED
);

  logic [7:0] link_data;
  logic       link_oe;
  logic       link_done;
  logic [7:0] link_rxcmd;
  logic       resetn_q;
  logic       led_q;
  logic       w_unused;

  // The board clock exists only for pin compatibility.
  assign w_unused = ^{CLK, link_rxcmd};

  ulpi_link #(
    .FUNC_CTRL_ADDR(FUNC_CTRL_ADDR),
    .FUNC_CTRL_VAL (FUNC_CTRL_VAL)
  ) u_link (
    .clk_i    (USB_CLKIN),
    .rst_ni   (NRST),
    .dir_i    (USB_DIR),
    .nxt_i    (USB_NXT),
    .data_i   (USB_DATA),
    .data_o   (link_data),
    .data_oe_o(link_oe),
    .stp_o    (USB_STP),
    .done_o   (link_done),
    .rxcmd_o  (link_rxcmd)
  );

  always_ff @(posedge USB_CLKIN or negedge NRST) begin
    if (!NRST) begin
      resetn_q <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      resetn_q <= 1'b1;
      led_q    <= link_done & USB_FAULTN;
    end
  end

  assign USB_DATA   = link_oe ? link_data : 8'hzz;
  assign USB_RESETN = resetn_q;
  assign USB_CS     = 1'b1;
  assign LED        = led_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_ulpi_top.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_usb_ulpi_top: vector table, corner sequences, random vs model.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_usb_ulpi_top;
  import ulpi_pkg::*;

  localparam logic [7:0] EXP_CMD = 8'h84;
  localparam logic [7:0] EXP_VAL = 8'h45;

  logic       clk60 = 1'b0;
  logic       clk100 = 1'b0;
  logic       nrst = 1'b0;
  logic       dir = 1'b1;
  logic       nxt = 1'b0;
  logic       faultn = 1'b1;
  logic [7:0] tb_data = 8'h00;
  wire  [7:0] usb_data;
  wire        stp, resetn, cs, led;

  int errors = 0;
  int checks = 0;

  always #8 clk60 = ~clk60;
  always #5 clk100 = ~clk100;

  assign usb_data = dir ? tb_data : 8'hzz;

  usb_ulpi_top dut (
    .USB_CLKIN (clk60),
    .NRST      (nrst),
    .CLK       (clk100),
    .USB_DATA  (usb_data),
    .USB_DIR   (dir),
    .USB_NXT   (nxt),
    .USB_FAULTN(faultn),
    .USB_STP   (stp),
    .USB_RESETN(resetn),
    .USB_CS    (cs),
    .LED       (led)
  );

  // Reference model: write progress 0 idle, 1 command, 2 data, 3 stop, 4 done.
  bit         m_prev_dir, m_up, m_rx_seen, m_done, m_resetn, m_led;
  int         m_phase;
  logic [7:0] m_rxcmd;

  typedef struct {
    bit         dir, nxt;
    logic [7:0] data;
    bit         faultn;
    bit         oe;
    logic [7:0] dout;
    bit         stp, led;
  } vec_t;

  vec_t tab[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_dir = 1'b1; m_up = 1'b0; m_rx_seen = 1'b0; m_done = 1'b0;
    m_resetn = 1'b0; m_led = 1'b0; m_phase = 0; m_rxcmd = 8'h00;
  endtask

  task automatic model_step();
    bit own;
    own = !dir && !m_prev_dir;
    m_led = ((m_phase == 3) || m_done) && faultn;
    m_resetn = 1'b1;
    case (m_phase)
      0: begin
        if (!m_up) begin
          if (!dir && m_prev_dir) m_up = 1'b1;
        end else if (m_rx_seen && own) begin
          m_phase = 1;
        end
      end
      1, 2: begin
        if (dir) m_phase = 0;
        else if (nxt) m_phase = m_phase + 1;
      end
      3: begin
        m_phase = 4;
        m_done = 1'b1;
      end
      default: ;
    endcase
    if (dir && m_prev_dir && !nxt) begin
      m_rxcmd = tb_data;
      m_rx_seen = 1'b1;
    end
    m_prev_dir = dir;
  endtask

  task automatic model_check();
    bit         e_oe;
    logic [7:0] e_data;
    e_oe   = !dir && !m_prev_dir;
    e_data = (m_phase == 1) ? EXP_CMD : (m_phase == 2) ? EXP_VAL : 8'h00;
    chk("m_oe", dut.link_oe, e_oe);
    if (e_oe) chk("m_data", usb_data, e_data);
    chk("m_stp", stp, m_phase == 3);
    chk("m_led", led, m_led);
    chk("m_resetn", resetn, m_resetn);
    chk("m_cs", cs, 1'b1);
  endtask

  task automatic apply(input bit d, input bit n, input logic [7:0] v, input bit f);
    dir = d; nxt = n; tb_data = v; faultn = f;
    #1;
  endtask

  task automatic advance();
    @(posedge clk60);
    model_step();
    @(negedge clk60);
  endtask

  task automatic cyc(input bit d, input bit n, input logic [7:0] v, input bit f);
    apply(d, n, v, f);
    model_check();
    advance();
  endtask

  task automatic do_reset();
    @(negedge clk60);
    dir = 1'b1; nxt = 1'b0; faultn = 1'b1;
    #2 nrst = 1'b0;
    #1;
    chk("rst_resetn", resetn, 1'b0);
    chk("rst_led", led, 1'b0);
    chk("rst_stp", stp, 1'b0);
    chk("rst_oe", dut.link_oe, 1'b0);
    chk("rst_state", dut.u_link.state_q, ST_WAIT_PHY);
    chk("rst_cs", cs, 1'b1);
    #57;
    @(negedge clk60);
    nrst = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(bit d, bit n, logic [7:0] v, bit f, bit oe, logic [7:0] o, bit s, bit l);
    vec_t t;
    t.dir = d; t.nxt = n; t.data = v; t.faultn = f; t.oe = oe; t.dout = o; t.stp = s; t.led = l;
    return t;
  endfunction

  initial begin
    tab[0]  = mk(1, 1, 8'hAA, 1, 0, 8'h00, 0, 0);
    tab[1]  = mk(1, 1, 8'hAA, 1, 0, 8'h00, 0, 0);
    tab[2]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    tab[3]  = mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    tab[4]  = mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    tab[5]  = mk(1, 0, 8'h11, 1, 0, 8'h00, 0, 0);
    tab[6]  = mk(1, 0, 8'h40, 1, 0, 8'h00, 0, 0);
    tab[7]  = mk(1, 0, 8'h40, 1, 0, 8'h00, 0, 0);
    tab[8]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    tab[9]  = mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    tab[10] = mk(0, 0, 8'h00, 1, 1, EXP_CMD, 0, 0);
    tab[11] = mk(0, 0, 8'h00, 1, 1, EXP_CMD, 0, 0);
    tab[12] = mk(0, 1, 8'h00, 1, 1, EXP_CMD, 0, 0);
    tab[13] = mk(0, 1, 8'h00, 1, 1, EXP_VAL, 0, 0);
    tab[14] = mk(0, 0, 8'h00, 1, 1, 8'h00, 1, 0);
    tab[15] = mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 1);
    tab[16] = mk(0, 0, 8'h00, 0, 1, 8'h00, 0, 1);
    tab[17] = mk(0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
    tab[18] = mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    tab[19] = mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 1);

    model_reset();
    do_reset();
    #1;
    chk("resetn_before_edge", resetn, 1'b0);
    @(negedge clk60);
    chk("resetn_after_edge", resetn, 1'b1);
    @(posedge clk60);
    model_step();
    @(negedge clk60);

    // Re-sync: restart cleanly so the table begins right after reset release.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(tab[i].dir, tab[i].nxt, tab[i].data, tab[i].faultn);
      chk($sformatf("tab%0d_oe", i), dut.link_oe, tab[i].oe);
      if (tab[i].oe) chk($sformatf("tab%0d_data", i), usb_data, tab[i].dout);
      chk($sformatf("tab%0d_stp", i), stp, tab[i].stp);
      chk($sformatf("tab%0d_led", i), led, tab[i].led);
      model_check();
      advance();
    end
    chk("tab_rxcmd", dut.u_link.rxcmd_q, 8'h40);

    // Abort: DIR rises while TXCMD is on the bus, then the write retries.
    do_reset();
    cyc(1, 0, 8'h40, 1);
    cyc(1, 0, 8'h40, 1);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);
    apply(0, 0, 8'h00, 1);
    chk("abort_pre_cmd", usb_data, EXP_CMD);
    model_check();
    advance();
    apply(1, 0, 8'h4C, 1);
    chk("abort_release", dut.link_oe, 1'b0);
    chk("abort_no_stp", stp, 1'b0);
    model_check();
    advance();
    cyc(1, 0, 8'h4C, 1);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'h00, 1);
    cyc(0, 1, 8'h00, 1);
    apply(0, 0, 8'h00, 1);
    chk("retry_stp", stp, 1'b1);
    model_check();
    advance();
    cyc(0, 0, 8'h00, 1);
    chk("retry_led", led, 1'b1);
    chk("retry_rxcmd", dut.u_link.rxcmd_q, 8'h4C);

    // NRST pulse after completion restarts from WAIT_PHY with LED cleared.
    do_reset();
    #1;
    chk("restart_state", dut.u_link.state_q, ST_WAIT_PHY);
    chk("restart_led", led, 1'b0);
    @(negedge clk60);
    model_step();

    for (int r = 0; r < 6; r++) begin
      bit d;
      do_reset();
      d = 1'b1;
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 7) == 0) d = ~d;
        cyc(d, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 15) != 0);
      end
      chk($sformatf("rand%0d_rxcmd", r), dut.u_link.rxcmd_q, m_rxcmd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
